// File: rtl/logic_ops_pkg.sv
// Shared encodings for the byte-serial logic unit.
//   OP_*   : 3-bit operation select values seen on the op port.
//   state_e: FSM states of the serial controller.
package logic_ops_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_NAND = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_NOTA = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/logic_slice_8bit.sv
// Combinational logic slice: applies one bitwise operation to a SLICE_W-wide pair.
//   x, y : operand slices
//   op   : operation select (logic_ops_pkg encodings)
//   z    : result slice
module logic_slice_8bit
  import logic_ops_pkg::*;
#(
  parameter int unsigned SLICE_W = 8
) (
  input  logic [SLICE_W-1:0] x,
  input  logic [SLICE_W-1:0] y,
  input  logic [2:0]         op,
  output logic [SLICE_W-1:0] z
);

  always_comb begin
    z = '0;
    unique case (op)
      OP_AND:  z = x & y;
      OP_OR:   z = x | y;
      OP_XOR:  z = x ^ y;
      OP_NOR:  z = ~(x | y);
      OP_NAND: z = ~(x & y);
      OP_XNOR: z = ~(x ^ y);
      OP_NOTA: z = ~x;
      OP_PASS: z = x;
      default: z = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_serial32.sv
// Byte-serial bitwise logic unit. One logic slice is reused over WIDTH/SLICE_W cycles;
// operands and op are captured on accept so port changes during a run have no effect.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (ready only when idle)
//   op, a, b            : operation select and operands
//   out_valid/out_ready : result handshake (result held until accepted)
//   result, zero        : computed value and result==0 flag
module logic_unit_serial32
  import logic_ops_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SLICE_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int unsigned N    = WIDTH / SLICE_W;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [2:0]        op_q, op_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              zero_q, zero_d;

  logic [SLICE_W-1:0] slice_x, slice_y, slice_z;

  assign slice_x = a_q[cnt_q*SLICE_W +: SLICE_W];
  assign slice_y = b_q[cnt_q*SLICE_W +: SLICE_W];

  logic_slice_8bit #(
    .SLICE_W(SLICE_W)
  ) u_slice (
    .x (slice_x),
    .y (slice_y),
    .op(op_q),
    .z (slice_z)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    zero_d   = zero_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          op_d     = op;
          result_d = '0;
          zero_d   = 1'b0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        result_d[cnt_q*SLICE_W +: SLICE_W] = slice_z;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          // Flag comes from result_d so it includes the slice written on this edge.
          zero_d  = (result_d == '0);
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_AND;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign zero      = zero_q;

endmodule
